// File: rtl/sram_req_adapter_pkg.sv
// Shared constants for the SRAM request adapter and its response buffer.
// Widths stay parametric at each use site; only defaults live here.
package sram_req_adapter_pkg;

  localparam int unsigned SRAM_DATA_WIDTH = 64;
  localparam int unsigned SRAM_NUM_WORDS  = 1024;
  localparam int unsigned SRAM_RSP_DEPTH  = 2;

  // Bits needed to hold an occupancy count in the range 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_req_adapter_if.sv
// Request/response and SRAM-side signal bundle for the SRAM request adapter.
// master = requester, slave = adapter, mem = SRAM macro side.
interface sram_req_adapter_if #(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned AW         = 10,
  localparam int unsigned BW         = (DATA_WIDTH + 7) / 8
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [AW-1:0]         req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BW-1:0]         req_be;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  logic                  sram_req;
  logic                  sram_we;
  logic [AW-1:0]         sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [BW-1:0]         sram_be;
  logic [DATA_WIDTH-1:0] sram_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, sram_rdata,
    output req_ready, rsp_valid, rsp_rdata,
           sram_req, sram_we, sram_addr, sram_wdata, sram_be
  );

  modport mem (
    input  sram_req, sram_we, sram_addr, sram_wdata, sram_be,
    output sram_rdata
  );

endinterface

// File: rtl/sram_req_adapter_fifo.sv
// fifo_v3: small first-word-fall-through FIFO used as the read response buffer.
// Head data is presented combinationally so a pushed word is visible the next cycle.
module fifo_v3
  import sram_req_adapter_pkg::*;
#(
  parameter  int unsigned DEPTH      = SRAM_RSP_DEPTH,
  parameter  int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  localparam int unsigned PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW         = cnt_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic [CW-1:0]         usage_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_next;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_next;
  logic [CW-1:0]         usage_q, usage_next;
  logic                  full;
  logic                  push_eff;
  logic                  pop_eff;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (usage_q == CW'(DEPTH));
  assign empty_o  = (usage_q == '0);
  assign usage_o  = usage_q;
  assign data_o   = mem_q[rd_ptr_q];
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign push_eff = push_i && (!full || pop_i);
  assign pop_eff  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_next = wr_ptr_q;
    rd_ptr_next = rd_ptr_q;
    usage_next  = usage_q;
    if (push_eff) wr_ptr_next = ptr_inc(wr_ptr_q);
    if (pop_eff)  rd_ptr_next = ptr_inc(rd_ptr_q);
    case ({push_eff, pop_eff})
      2'b10:   usage_next = usage_q + 1'b1;
      2'b01:   usage_next = usage_q - 1'b1;
      default: usage_next = usage_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_next;
      rd_ptr_q <= rd_ptr_next;
      usage_q  <= usage_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= data_i;
  end

  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full && !pop_i));

endmodule

// File: rtl/sram_req_adapter.sv
// Valid/ready front end for a single-port SRAM with one-cycle read latency.
// Reads are only admitted when a response buffer slot is guaranteed for them.
module sram_req_adapter
  import sram_req_adapter_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter  int unsigned NUM_WORDS  = SRAM_NUM_WORDS,
  parameter  int unsigned RSP_DEPTH  = SRAM_RSP_DEPTH,
  localparam int unsigned AW         = $clog2(NUM_WORDS),
  localparam int unsigned BW         = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BW-1:0]         req_be_i,

  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,

  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BW-1:0]         sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int unsigned CW = cnt_width(RSP_DEPTH);
  localparam int unsigned OW = CW + 1;

  logic          rd_pending_q;
  logic          fifo_empty;
  logic [CW-1:0] fifo_usage;
  logic          pop;
  logic [OW-1:0] occupancy;

  assign rsp_valid_o = !fifo_empty;
  assign pop         = rsp_valid_o && rsp_ready_i;

  // Slots already claimed (buffered + in flight) minus the one leaving this cycle.
  assign occupancy   = OW'(fifo_usage) + OW'(rd_pending_q) - OW'(pop);
  assign req_ready_o = req_we_i || (occupancy < OW'(RSP_DEPTH));

  assign sram_req_o   = req_valid_i && req_ready_o;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pending_q <= 1'b0;
    end else begin
      rd_pending_q <= sram_req_o && !req_we_i;
    end
  end

  fifo_v3 #(
    .DEPTH      (RSP_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rd_pending_q),
    .data_i  (sram_rdata_i),
    .pop_i   (pop),
    .data_o  (rsp_rdata_o),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

endmodule

// File: tb/tb_sram_req_adapter.sv
// Bench for sram_req_adapter: directed scenarios plus a long random mix,
// all checked against a queue-based model of outstanding read responses.
module tb_sram_req_adapter;

  localparam int DW = 64;
  localparam int NW = 1024;
  localparam int RD = 2;
  localparam int AW = $clog2(NW);
  localparam int BW = (DW + 7) / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_req_adapter_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

  sram_req_adapter #(
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW),
    .RSP_DEPTH  (RD)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (bus.req_valid),
    .req_ready_o  (bus.req_ready),
    .req_we_i     (bus.req_we),
    .req_addr_i   (bus.req_addr),
    .req_wdata_i  (bus.req_wdata),
    .req_be_i     (bus.req_be),
    .rsp_valid_o  (bus.rsp_valid),
    .rsp_ready_i  (bus.rsp_ready),
    .rsp_rdata_o  (bus.rsp_rdata),
    .sram_req_o   (bus.sram_req),
    .sram_we_o    (bus.sram_we),
    .sram_addr_o  (bus.sram_addr),
    .sram_wdata_o (bus.sram_wdata),
    .sram_be_o    (bus.sram_be),
    .sram_rdata_i (bus.sram_rdata)
  );

  // SRAM macro stand-in: writes commit at the edge, read data one cycle later.
  logic [DW-1:0] sram_mem [NW];
  always @(posedge clk) begin
    if (bus.sram_req) begin
      if (bus.sram_we) begin
        for (int b = 0; b < BW; b++)
          if (bus.sram_be[b]) sram_mem[bus.sram_addr][b*8 +: 8] <= bus.sram_wdata[b*8 +: 8];
      end else begin
        bus.sram_rdata <= sram_mem[bus.sram_addr];
      end
    end
  end

  // Reference: expected memory image and in-order queue of outstanding reads.
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic [DW-1:0] ref_mem [NW];
  exp_t          exp_q [$];

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            acc_cnt = 0;
  int            pop_cnt = 0;
  int            last_pop_cyc = 0;
  logic [DW-1:0] last_pop;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BW-1:0] be, input logic rr);
    logic head_vis, pop_m, ready_m, acc;
    int   outst;
    logic [DW-1:0] nv;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    bus.rsp_ready = rr;
    #2;
    // A read accepted in cycle c is at the buffer head no earlier than cycle c+2.
    head_vis = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
    check_val("rsp_valid", 64'(bus.rsp_valid), 64'(head_vis));
    if (head_vis) check_val("rsp_rdata", bus.rsp_rdata, exp_q[0].data);
    pop_m   = head_vis && rr;
    outst   = exp_q.size() - (pop_m ? 1 : 0);
    ready_m = we || (outst < RD);
    check_val("req_ready", 64'(bus.req_ready), 64'(ready_m));
    acc = v && ready_m;
    check_val("sram_req", 64'(bus.sram_req), 64'(acc));
    if (acc) begin
      check_val("sram_addr", 64'(bus.sram_addr), 64'(a));
      check_val("sram_we", 64'(bus.sram_we), 64'(we));
      if (we) begin
        check_val("sram_wdata", bus.sram_wdata, d);
        check_val("sram_be", 64'(bus.sram_be), 64'(be));
      end
    end
    $display("cyc=%0d v=%0b we=%0b a=%0d rr=%0b ready=%0b rsp_v=%0b rdata=%h",
             cyc, v, we, a, rr, bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
    if (pop_m) begin
      last_pop     = bus.rsp_rdata;
      last_pop_cyc = cyc;
      pop_cnt++;
      exp_q.delete(0);
    end
    if (acc) begin
      acc_cnt++;
      if (we) begin
        nv = ref_mem[a];
        for (int b = 0; b < BW; b++)
          if (be[b]) nv[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[a] = nv;
      end else begin
        exp_q.push_back('{ref_mem[a], cyc});
      end
    end
    cyc++;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [BW-1:0] be, input logic rr);
    step(1'b1, 1'b1, a, d, be, rr);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic rr);
    step(1'b1, 1'b0, a, '0, '0, rr);
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, '0, '0, '0, rr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("rst_req_ready", 64'(bus.req_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    int a0, p0, rc;
    logic [DW-1:0] k033, k034w, k034r;
    k033  = 64'hDEAD_BEEF_0000_1111;
    k034w = 64'hAAAA_AAAA_5555_5555;
    k034r = 64'h0000_0000_5555_5555;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NW; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    #1;
    check_val("por_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("por_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read of the same word on consecutive cycles.
    wr(5, k033, 8'hFF, 1'b1);
    rc = cyc;
    rd(5, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check_val("d033_data", last_pop, k033);
    check_val("d033_lat", 64'(last_pop_cyc - rc), 64'd2);

    // Partial byte-enable write over zero.
    wr(7, k034w, 8'h0F, 1'b1);
    rd(7, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check_val("d034_data", last_pop, k034r);

    // Back-to-back reads with the consumer always ready.
    p0 = pop_cnt;
    for (int i = 0; i < 16; i++) rd(AW'(i), 1'b1);
    repeat (3) idle(1'b1);
    check_val("d035_count", 64'(pop_cnt - p0), 64'd16);

    // Stalled consumer: only RSP_DEPTH reads admitted, writes still flow.
    a0 = acc_cnt;
    for (int i = 0; i < 6; i++) rd(AW'(i), 1'b0);
    check_val("d036_rd_acc", 64'(acc_cnt - a0), 64'(RD));
    wr(20, 64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b0);
    check_val("d036_wr_acc", 64'(acc_cnt - a0), 64'(RD + 1));
    p0 = pop_cnt;
    repeat (4) idle(1'b1);
    check_val("d036_drain", 64'(pop_cnt - p0), 64'(RD));

    // Reset with a read in flight and responses buffered.
    rd(1, 1'b0);
    rd(2, 1'b0);
    do_reset();
    rc = cyc;
    rd(5, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check_val("d037_data", last_pop, k033);
    check_val("d037_lat", 64'(last_pop_cyc - rc), 64'd2);

    // Random mix over a small address window to force read-after-write hits.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           AW'($urandom_range(0, 31)), {$urandom, $urandom}, BW'($urandom),
           $urandom_range(0, 9) < 7);
    end
    repeat (6) idle(1'b1);
    check_val("drain_empty", 64'(exp_q.size()), 64'd0);
    check_val("final_rsp_valid", 64'(bus.rsp_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
